// File: rtl/sha256_msg_scheduler_if.sv
// Handshake bundle between the message packer, the schedule stage and the
// compression core. The scheduler sits on the slave side.
interface sha256_msg_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  MP_dv_in;
  logic                  W_ready_in;
  logic [DATA_WIDTH-1:0] W_out;
  logic                  W_valid_out;
  logic [5:0]            round_idx_out;
  logic                  busy_out;
  logic                  block_done_out;
  logic                  overflow_err_out;

  modport slave (
    input  data_in, MP_dv_in, W_ready_in,
    output W_out, W_valid_out, round_idx_out, busy_out, block_done_out,
           overflow_err_out
  );

  modport master (
    output data_in, MP_dv_in, W_ready_in,
    input  W_out, W_valid_out, round_idx_out, busy_out, block_done_out,
           overflow_err_out
  );
endinterface

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message schedule: captures 16 message words, then streams
// W0..W63 one per handshake using a rolling 16-word window. Only a 32-bit
// word width is meaningful (the sigma rotations are fixed to 32 bits).
module sha256_msg_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sha256_msg_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - 1);

  state_e                state_q;
  logic [4:0]            ld_cnt_q;
  logic [5:0]            t_q;
  logic [DATA_WIDTH-1:0] w_q [16];
  logic [DATA_WIDTH-1:0] w15_d;
  logic                  wr_en;
  logic [3:0]            wr_idx;
  logic                  hs;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Word acceptance is only legal while collecting a block; the first word
  // of a block always lands in slot 0.
  assign wr_en  = bus.MP_dv_in && (state_q == IDLE || state_q == LOAD);
  assign wr_idx = (state_q == IDLE) ? 4'd0 : ld_cnt_q[3:0];
  assign hs     = (state_q == EXPAND) && bus.W_ready_in;

  // Next schedule word entering the top of the window, W[t+16]; still
  // computed for the last 16 rounds even though those values drain unused.
  assign w15_d = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  // Control FSM: load counter and round counter advance with their state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
      t_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.MP_dv_in) begin
            ld_cnt_q <= 5'd1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (bus.MP_dv_in) begin
            ld_cnt_q <= ld_cnt_q + 5'd1;
            if (ld_cnt_q == 5'd15) begin
              t_q     <= '0;
              state_q <= EXPAND;
            end
          end
        end
        EXPAND: begin
          if (bus.W_ready_in) begin
            t_q <= t_q + 6'd1;
            if (t_q == T_LAST) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Window: shifts down on each consumed word, otherwise takes loaded words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (hs) begin
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w15_d;
    end else if (wr_en) begin
      w_q[wr_idx] <= bus.data_in;
    end
  end

  // Outputs decode registered state only, except the overflow flag which
  // must flag the offending word in the same cycle it is presented.
  assign bus.W_valid_out      = (state_q == EXPAND);
  assign bus.W_out            = (state_q == EXPAND) ? w_q[0] : '0;
  assign bus.round_idx_out    = (state_q == EXPAND) ? t_q : '0;
  assign bus.busy_out         = (state_q != IDLE);
  assign bus.block_done_out   = (state_q == DONE);
  assign bus.overflow_err_out = bus.MP_dv_in &&
                                (state_q == EXPAND || state_q == DONE);

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Self-checking bench: golden schedule computed with the textbook W[t]
// recurrence over a full 64-entry array, compared word by word.
module tb_sha256_msg_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_scheduler_if #(.DATA_WIDTH(32)) bus();

  sha256_msg_scheduler #(.DATA_WIDTH(32), .NUM_ROUNDS(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] msg  [16];
  logic [31:0] gold [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the SHA-256 definition.
  function automatic void build_gold();
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) gold[t] = msg[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(gold[t-15], 7) ^ rotr(gold[t-15], 18) ^ (gold[t-15] >> 3);
      s1 = rotr(gold[t-2], 17) ^ rotr(gold[t-2], 19) ^ (gold[t-2] >> 10);
      gold[t] = s1 + gold[t-7] + s0 + gold[t-16];
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_gold();
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_gold();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_W"},     bus.W_out, 0);
    chk({tag, "_vld"},   bus.W_valid_out, 0);
    chk({tag, "_idx"},   bus.round_idx_out, 0);
    chk({tag, "_busy"},  bus.busy_out, 0);
    chk({tag, "_done"},  bus.block_done_out, 0);
    chk({tag, "_ovf"},   bus.overflow_err_out, 0);
  endtask

  // Streams msg[] in; optional idle gap before every word after the first.
  task automatic load(input bit gapped);
    for (int i = 0; i < 16; i++) begin
      if (gapped && i > 0) begin
        bus.MP_dv_in = 1'b0;
        #1;
        chk("gap_vld", bus.W_valid_out, 0);
        step();
      end
      bus.MP_dv_in = 1'b1;
      bus.data_in  = msg[i];
      #1;
      chk("load_vld", bus.W_valid_out, 0);
      chk("load_ovf", bus.overflow_err_out, 0);
      step();
    end
    bus.MP_dv_in = 1'b0;
    bus.data_in  = '0;
  endtask

  // Consumes the schedule against gold[]. Ends in the cycle after DONE
  // (IDLE) unless aborted by reset at round rst_t.
  task automatic expand(input int bp_t, input int bp_len, input int ovf_t,
                        input int rst_t, output int done_cyc);
    int  idx = 0, stall = 0, guard = 0, ovf_cnt = 0;
    bit  ovf_done = 1'b0;
    done_cyc = -1;
    while (idx < 64 && guard < 300) begin
      guard++;
      bus.W_ready_in = !(idx == bp_t && stall < bp_len);
      bus.MP_dv_in   = (idx == ovf_t) && !ovf_done;
      bus.data_in    = bus.MP_dv_in ? 32'hDEADBEEF : 32'h0;
      #1;
      chk("exp_vld",  bus.W_valid_out, 1);
      chk("exp_W",    bus.W_out, gold[idx]);
      chk("exp_idx",  bus.round_idx_out, idx);
      chk("exp_done", bus.block_done_out, 0);
      chk("exp_ovf",  bus.overflow_err_out, bus.MP_dv_in);
      if (bus.overflow_err_out) ovf_cnt++;
      if (idx == rst_t) begin
        rst_n = 1'b0;
        bus.MP_dv_in = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk_all_zero("midrst");
        bus.W_ready_in = 1'b0;
        return;
      end
      if (bus.MP_dv_in) ovf_done = 1'b1;
      if (!bus.W_ready_in) stall++;
      else idx++;
      step();
    end
    bus.MP_dv_in   = 1'b0;
    bus.data_in    = '0;
    bus.W_ready_in = 1'b0;
    chk("exp_count", idx, 64);
    chk("ovf_pulses", ovf_cnt, (ovf_t >= 0) ? 1 : 0);
    #1;
    chk("done_pulse", bus.block_done_out, 1);
    chk("done_vld",   bus.W_valid_out, 0);
    chk("done_W",     bus.W_out, 0);
    chk("done_busy",  bus.busy_out, 1);
    done_cyc = cyc;
    step();
    chk("idle_busy", bus.busy_out, 0);
    chk("idle_done", bus.block_done_out, 0);
  endtask

  initial begin
    int d1, d2;
    bus.data_in    = '0;
    bus.MP_dv_in   = 1'b0;
    bus.W_ready_in = 1'b0;

    // Reset
    rst_n = 1'b0;
    step();
    step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    step();
    chk_all_zero("post_rst");

    // Golden "abc" values from the reference model
    set_abc();
    chk("gold_W0",  gold[0],  32'h61626380);
    chk("gold_W15", gold[15], 32'h00000018);
    chk("gold_W16", gold[16], 32'h61626380);
    chk("gold_W17", gold[17], 32'h000F0000);

    // Plain abc block
    load(1'b0);
    expand(-1, 0, -1, -1, d1);

    // Gapped load
    load(1'b1);
    expand(-1, 0, -1, -1, d1);

    // Backpressure at t=16 for 5 cycles
    load(1'b0);
    expand(16, 5, -1, -1, d1);

    // Overflow during EXPAND at t=3
    load(1'b0);
    expand(-1, 0, 3, -1, d1);

    // Reset at t=30, then a clean abc block
    load(1'b0);
    expand(-1, 0, -1, 30, d1);
    chk("rst_abort_done", d1, -1);
    step();
    chk_all_zero("after_abort");
    load(1'b0);
    expand(-1, 0, -1, -1, d1);

    // Back-to-back random blocks, second starts in the IDLE cycle after DONE
    set_rand();
    load(1'b0);
    expand(-1, 0, -1, -1, d1);
    set_rand();
    load(1'b0);
    expand(-1, 0, -1, -1, d2);
    chk("b2b_period", d2 - d1, 81);

    // A couple of extra random blocks with random backpressure point
    for (int k = 0; k < 2; k++) begin
      set_rand();
      load(k[0]);
      expand($urandom_range(0, 63), $urandom_range(1, 4), -1, -1, d1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/sha256_msg_scheduler.md
# sha256_msg_scheduler

Message-schedule stage of the SHA-256 datapath, directly downstream of the UART message packer. It captures the 16 32-bit words of one 512-bit block as the packer streams them. It then expands them on the fly into the 64-entry schedule W0..W63 using a rolling 16-word window, and feeds one word per round to the compression core under a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported.
- NUM_ROUNDS, 64, schedule words emitted per block.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- data_in  input  DATA_WIDTH  message word from packer, big-endian word order (first word = M0).
- MP_dv_in  input  1  data_in valid; one word accepted per cycle it is high.
- W_ready_in  input  1  compression core consumes W_out this cycle.
- W_out  output  DATA_WIDTH  current schedule word W_t.
- W_valid_out  output  1  W_out / round_idx_out valid.
- round_idx_out  output  6  t of the word on W_out.
- busy_out  output  1  high in every state except IDLE.
- block_done_out  output  1  one-cycle pulse after W63 is consumed.
- overflow_err_out  output  1  one-cycle pulse when MP_dv_in arrives while the block cannot accept it; the word is dropped.

## Operation
- Storage: window w[0..15] of 32-bit registers, w[0] oldest; load counter ld_cnt (5 bits); round counter t (6 bits).
- Functions:
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - All additions are modulo 2^32, with carries discarded.
- FSM states and transitions:
  - IDLE
    - MP_dv_in -> write w[0]=data_in, ld_cnt=1, go LOAD.
  - LOAD
    - Each MP_dv_in writes w[ld_cnt]=data_in and increments ld_cnt.
    - Gaps (MP_dv_in low) are allowed and stall loading.
    - The write with ld_cnt==15 goes EXPAND with t=0.
  - EXPAND
    - W_out=w[0], W_valid_out=1, round_idx_out=t.
    - On W_valid_out & W_ready_in:
      - Shift window down: w[i]<=w[i+1] for i=0..14.
      - Set w[15] <= sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0].
      - Increment t.
    - Handshake at t==63 goes DONE.
    - The expansion is also computed for t>=48; those results are never emitted.
  - DONE
    - One cycle long; block_done_out=1, then return to IDLE.
- MP_dv_in during EXPAND or DONE:
  - The word is ignored.
  - overflow_err_out pulses in that cycle.
  - Window and counters are unaffected.
- W_ready_in outside EXPAND is ignored.

## Timing
- Reset (rst_n low at a clock edge): state IDLE, all w, ld_cnt and t cleared. All outputs are 0 in the following cycle: W_out, W_valid_out, round_idx_out, busy_out, block_done_out and overflow_err_out.
- Reset mid-LOAD or mid-EXPAND aborts the block. No block_done_out is produced, and the partial block is discarded.
- Load latency: if the 16th word is accepted at edge N, W_valid_out=1 with W_out=W0 from edge N (the cycle after acceptance).
- Throughput: with W_ready_in held high, W0..W63 appear on 64 consecutive cycles.
  - block_done_out is high the cycle after W63's handshake.
  - busy_out drops the cycle after that.
  - Minimum block period: 16 + 64 + 1 = 81 cycles.
- Backpressure: while W_ready_in is low in EXPAND, W_out, round_idx_out and the window hold exactly.
- W_out is a register output (w[0]). It has no combinational path from W_ready_in or MP_dv_in.
- W_out is driven as 0 whenever W_valid_out=0.
- A new block's first word may be accepted in the IDLE cycle directly after DONE.

## Test plan
- "abc" block: M0=0x61626380, M1..M14=0, M15=0x00000018 on 16 consecutive cycles, W_ready_in=1.
  - Required: W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - Required: 64 valid words, round_idx_out 0..63, then one block_done_out pulse.
- Gapped load: same words with MP_dv_in low every other cycle -> identical W sequence; W_valid_out first rises only after the 16th word.
- Backpressure: "abc" block, W_ready_in low for 5 cycles at t=16 -> W_out holds 0x61626380 with round_idx_out=16 throughout, then resumes with W17=0x000F0000.
- Overflow: assert MP_dv_in with 0xDEADBEEF during EXPAND at t=3 -> overflow_err_out pulses once; the remaining W sequence is unchanged from the golden model.
- Reset mid-operation: rst_n low for one cycle at t=30 -> next cycle all outputs 0 and busy_out=0; a following "abc" block reproduces the golden W0..W63.
- Back-to-back: two random blocks with the second's first word in the IDLE cycle after DONE -> both W sequences match the software model and two block_done_out pulses occur, 81 cycles apart.
